lcd_write_arbiter: RTL and testbench
====================================

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter SETTLE_CYC, default 262142, SHALL set the idle cycles inserted after every completed LCD byte write.
REQ-002 Parameter INIT_EN, default 1, SHALL enable the power-on LCD init sequence when 1.
REQ-003 iCLK  in  1  sole clock; every flop SHALL be rising-edge iCLK.
REQ-004 iRST_N  in  1  reset; asynchronous, active-low.
REQ-005 i_req0 / i_req1  in  1  write request, requester 0 / 1.
REQ-006 i_rs0 / i_rs1  in  1  register select per requester (0 = command, 1 = data).
REQ-007 i_data0 / i_data1  in  8  byte per requester.
REQ-008 o_ack0 / o_ack1  out  1  one-cycle grant pulse; the byte is captured on that cycle.
REQ-009 o_start  out  1  start level to the LCD byte-write engine.
REQ-010 o_rs, o_data  out  1, 8  RS and byte to the engine.
REQ-011 i_done  in  1  engine done level, high after a write until the next start edge.
REQ-012 o_ready  out  1  high only in IDLE.
REQ-013 o_init_done  out  1  high once the init sequence has finished (or immediately if INIT_EN=0).

Function
REQ-014 FSM states SHALL be INIT_ISSUE, IDLE, ISSUE, GUARD, WAIT_DONE, SETTLE; a 3-bit init index and an 18-bit settle counter SHALL exist.
REQ-015 INIT_EN=1: after reset the FSM SHALL issue, in order, RS=0 bytes 0x38, 0x0C, 0x01, 0x06, 0x80, each through ISSUE..SETTLE, with no requester ack in that period.
REQ-016 After the 5th init byte's SETTLE, o_init_done SHALL rise and the FSM SHALL enter IDLE; INIT_EN=0 SHALL enter IDLE on the first clock after reset.
REQ-017 IDLE, exactly one req high: that requester SHALL be granted.
REQ-018 IDLE, both high: requester named by the round-robin pointer SHALL be granted; pointer resets to 0 and toggles to the other requester after every grant.
REQ-019 On grant: o_ackN high for exactly that cycle; o_rs/o_data SHALL load that requester's i_rsN/i_dataN; next state ISSUE.
REQ-020 Requesters SHALL hold req/rs/data stable until ack; req held after ack SHALL be treated as a new request.
REQ-021 ISSUE: o_start SHALL go 1; next state GUARD.
REQ-022 GUARD SHALL last 2 cycles with i_done ignored (masks stale done from the previous write); then WAIT_DONE.
REQ-023 WAIT_DONE: on i_done=1, o_start SHALL go 0 and the FSM SHALL enter SETTLE; no timeout.
REQ-024 SETTLE: counter SHALL count 0..SETTLE_CYC-1, then clear; next state IDLE (or INIT_ISSUE if init bytes remain).
REQ-025 o_rs/o_data SHALL remain stable from load until the next grant or init load.
REQ-026 o_ready SHALL be 1 exactly while in IDLE; requests outside IDLE SHALL wait, never be dropped.
REQ-027 Grant-to-next-possible-grant latency SHALL be 1 + 1 + 2 + D + SETTLE_CYC + 1 cycles, D = WAIT_DONE cycles.

Reset
REQ-028 iRST_N low SHALL immediately force: state INIT_ISSUE (IDLE if INIT_EN=0), o_start=0, o_rs=0, o_data=0x00, o_ack0=o_ack1=0, o_ready=0, o_init_done=0, pointer=0, counters=0.
REQ-029 Reset mid-write SHALL abort the write with no ack or retry; init SHALL re-run after release.

Verification (SETTLE_CYC=4; engine model raises i_done 20 cycles after start rise, clears it 1 cycle after start rise)
REQ-030 Reset release, INIT_EN=1 -> o_data sequence 0x38,0x0C,0x01,0x06,0x80 with o_rs=0; no ack; then o_init_done=1, o_ready=1.
REQ-031 IDLE, i_req0=1, rs0=1, data0=0x41 -> o_ack0 one cycle, o_data=0x41, o_rs=1, o_start rises next cycle, falls when i_done=1.
REQ-032 Both req high, data0=0x30, data1=0x31, held -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-033 Stale i_done=1 held at ISSUE -> o_start stays 1 through GUARD; FSM does not leave WAIT_DONE until a fresh i_done rise.
REQ-034 iRST_N pulsed low during WAIT_DONE -> o_start=0 asynchronously; after release init restarts at 0x38.
REQ-035 Back-to-back single requester -> consecutive acks exactly 1+1+2+20+4+1 cycles apart.

Source files
------------

// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if: requester and LCD byte-engine signals of the arbiter.
// slave = arbiter side, master = requesters plus engine (bench side).
//   i_req0/1, i_rs0/1, i_data0/1 : write requests, RS and byte per requester
//   o_ack0/1                     : one-cycle grant pulse, byte captured then
//   o_start, o_rs, o_data        : start level, RS and byte to the engine
//   i_done                       : engine done level
//   o_ready, o_init_done         : idle flag, init sequence finished
interface lcd_write_arbiter_if;
  logic       i_req0;
  logic       i_req1;
  logic       i_rs0;
  logic       i_rs1;
  logic [7:0] i_data0;
  logic [7:0] i_data1;
  logic       o_ack0;
  logic       o_ack1;
  logic       o_start;
  logic       o_rs;
  logic [7:0] o_data;
  logic       i_done;
  logic       o_ready;
  logic       o_init_done;

  modport slave (
    input  i_req0,
    input  i_req1,
    input  i_rs0,
    input  i_rs1,
    input  i_data0,
    input  i_data1,
    input  i_done,
    output o_ack0,
    output o_ack1,
    output o_start,
    output o_rs,
    output o_data,
    output o_ready,
    output o_init_done
  );

  modport master (
    output i_req0,
    output i_req1,
    output i_rs0,
    output i_rs1,
    output i_data0,
    output i_data1,
    output i_done,
    input  o_ack0,
    input  o_ack1,
    input  o_start,
    input  o_rs,
    input  o_data,
    input  o_ready,
    input  o_init_done
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: two-requester round-robin front end for an LCD
// byte-write engine, with optional power-on init sequence.
// Ports: iCLK (rising edge), iRST_N (async, active low),
//   bus (lcd_write_arbiter_if.slave): requests/acks, engine start/rs/data/done,
//   o_ready (idle), o_init_done (init sequence complete).
// Every write runs ISSUE, GUARD (2 cycles, done ignored), WAIT_DONE, SETTLE.
module lcd_write_arbiter #(
  parameter int SETTLE_CYC = 262142,
  parameter int INIT_EN    = 1
) (
  input logic                iCLK,
  input logic                iRST_N,
  lcd_write_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    INIT_ISSUE,
    IDLE,
    ISSUE,
    GUARD,
    WAIT_DONE,
    SETTLE
  } state_t;

  localparam logic [17:0] SETTLE_LIM = 18'(SETTLE_CYC);
  localparam logic [2:0]  INIT_LAST  = 3'd4;
  localparam logic        HAS_INIT   = (INIT_EN != 0);
  localparam state_t      RST_STATE  = HAS_INIT ? INIT_ISSUE : IDLE;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [17:0] cnt_q, cnt_d;
  logic        guard_q, guard_d;
  logic        ptr_q, ptr_d;
  logic        start_q, start_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        run_q;
  logic        gnt0, gnt1;
  logic        ack0, ack1;
  logic        init_pend;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h38;
      3'd1:    b = 8'h0C;
      3'd2:    b = 8'h01;
      3'd3:    b = 8'h06;
      default: b = 8'h80;
    endcase
    return b;
  endfunction

  // Pointer only breaks ties; a lone request always wins.
  assign gnt0 = bus.i_req0 & (~bus.i_req1 | ~ptr_q);
  assign gnt1 = bus.i_req1 & (~bus.i_req0 | ptr_q);

  assign init_pend = HAS_INIT & ~init_done_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    guard_d     = guard_q;
    ptr_d       = ptr_q;
    start_d     = start_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q | ~HAS_INIT;
    ack0        = 1'b0;
    ack1        = 1'b0;
    unique case (state_q)
      INIT_ISSUE: begin
        rs_d    = 1'b0;
        data_d  = init_byte(idx_q);
        start_d = 1'b1;
        state_d = ISSUE;
      end
      IDLE: begin
        // run_q keeps grants off until the first clock after reset.
        if (run_q) begin
          unique case (1'b1)
            gnt0: begin
              ack0    = 1'b1;
              rs_d    = bus.i_rs0;
              data_d  = bus.i_data0;
              ptr_d   = 1'b1;
              start_d = 1'b1;
              state_d = ISSUE;
            end
            gnt1: begin
              ack1    = 1'b1;
              rs_d    = bus.i_rs1;
              data_d  = bus.i_data1;
              ptr_d   = 1'b0;
              start_d = 1'b1;
              state_d = ISSUE;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        guard_d = 1'b0;
        state_d = GUARD;
      end
      GUARD: begin
        // Done may still be high from the previous write here.
        if (guard_q) begin
          guard_d = 1'b0;
          state_d = WAIT_DONE;
        end else begin
          guard_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.i_done) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Values 0..LIM-1 are the idle cycles; reaching LIM clears it.
        if (cnt_q == SETTLE_LIM) begin
          cnt_d = '0;
          if (init_pend) begin
            if (idx_q == INIT_LAST) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = INIT_ISSUE;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 18'd1;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= RST_STATE;
      idx_q       <= '0;
      cnt_q       <= '0;
      guard_q     <= 1'b0;
      ptr_q       <= 1'b0;
      start_q     <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      guard_q     <= guard_d;
      ptr_q       <= ptr_d;
      start_q     <= start_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      run_q       <= 1'b1;
    end
  end

  assign bus.o_ack0      = ack0;
  assign bus.o_ack1      = ack1;
  assign bus.o_start     = start_q;
  assign bus.o_rs        = rs_q;
  assign bus.o_data      = data_q;
  assign bus.o_ready     = run_q & (state_q == IDLE);
  assign bus.o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: vector table, corner sequences and a random run
// checked against a cycle-arithmetic model of the arbiter.
module tb_lcd_write_arbiter;

  localparam int SETTLE   = 4;
  localparam int DONE_DLY = 20;
  // Engine sees o_start two cycles late, so WAIT_DONE lasts DONE_DLY.
  localparam int WR_CYC   = 1 + 1 + 2 + DONE_DLY + SETTLE + 1;
  localparam int START_HI = 1 + 2 + DONE_DLY;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic force_done = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lcd_write_arbiter_if bus ();
  lcd_write_arbiter_if bus0 ();

  lcd_write_arbiter #(.SETTLE_CYC(SETTLE), .INIT_EN(1)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus)
  );

  lcd_write_arbiter #(.SETTLE_CYC(SETTLE), .INIT_EN(0)) dut0 (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus0)
  );

  assign bus0.i_req0  = 1'b0;
  assign bus0.i_req1  = 1'b0;
  assign bus0.i_rs0   = 1'b0;
  assign bus0.i_rs1   = 1'b0;
  assign bus0.i_data0 = 8'h00;
  assign bus0.i_data1 = 8'h00;
  assign bus0.i_done  = 1'b0;

  // Engine: 2-flop view of o_start; done clears 1 cycle after that view
  // rises and sets DONE_DLY cycles after it, then holds.
  logic s1, s2, s3, eng_done;
  int   eng_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      eng_done <= 1'b0; eng_cnt <= 0;
    end else begin
      s1 <= bus.o_start; s2 <= s1; s3 <= s2;
      if (s2 && !s3) begin
        eng_done <= 1'b0; eng_cnt <= 1;
      end else if (eng_cnt == DONE_DLY - 1) begin
        eng_done <= 1'b1; eng_cnt <= 0;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end
  assign bus.i_done = eng_done | force_done;

  typedef struct {
    logic r0, r1, rs0, rs1;
    logic [7:0] d0, d1;
    logic a0, a1, ers;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drop_reqs();
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      n_chk++; n_err++;
      $display("FAIL wait_ready: o_ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  // Called at a negedge; asserts reset mid-cycle, away from any edge.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_start"}, bus.o_start, 0);
    chk({tag, "_ack0"}, bus.o_ack0, 0);
    chk({tag, "_ack1"}, bus.o_ack1, 0);
    chk({tag, "_ready"}, bus.o_ready, 0);
    chk({tag, "_initdone"}, bus.o_init_done, 0);
    chk({tag, "_rs"}, bus.o_rs, 0);
    chk({tag, "_data"}, bus.o_data, 8'h00);
    chk({tag, "_ready_ni"}, bus0.o_ready, 0);
    chk({tag, "_initdone_ni"}, bus0.o_init_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_init(input string tag);
    logic [8:0] seen[$];
    logic [7:0] exp_b[5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    int   n = 0;
    logic prev = 1'b0;
    bit   ack_seen = 0;
    bit   rdy_early = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_ni_ready"}, bus0.o_ready, 1);
        chk({tag, "_ni_initdone"}, bus0.o_init_done, 1);
      end
      if (bus.o_ack0 || bus.o_ack1) ack_seen = 1;
      if (bus.o_ready && !bus.o_init_done) rdy_early = 1;
      if (bus.o_start && !prev) seen.push_back({bus.o_rs, bus.o_data});
      prev = bus.o_start;
    end while (!bus.o_init_done && n < 400);
    chk({tag, "_cycles"}, n, 5 * WR_CYC);
    chk({tag, "_nbytes"}, seen.size(), 5);
    for (int i = 0; i < seen.size() && i < 5; i++)
      chk($sformatf("%s_byte%0d", tag, i), seen[i], {1'b0, exp_b[i]});
    chk({tag, "_noack"}, ack_seen, 0);
    chk({tag, "_ready_early"}, rdy_early, 0);
    chk({tag, "_ready"}, bus.o_ready, 1);
  endtask

  task automatic run_random(input int ncyc);
    int next_free = 0;
    int gc = -1000;
    int ptr = 0;
    int g;
    logic lrs = 1'b0;
    logic [7:0] ldat = 8'h80;
    bit p0 = 0, p1 = 0;
    logic r0s = 1'b0, r1s = 1'b0;
    logic [7:0] r0d = 8'h00, r1d = 8'h00;
    bit free, exp_start;
    for (int c = 0; c < ncyc; c++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; r0s = 1'($urandom_range(0, 1)); r0d = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; r1s = 1'($urandom_range(0, 1)); r1d = 8'($urandom);
      end
      bus.i_req0 = p0; bus.i_rs0 = r0s; bus.i_data0 = r0d;
      bus.i_req1 = p1; bus.i_rs1 = r1s; bus.i_data1 = r1d;
      #1;
      free = (c >= next_free);
      g = -1;
      if (free) begin
        if (p0 && p1) g = ptr;
        else if (p0) g = 0;
        else if (p1) g = 1;
      end
      exp_start = (c >= gc + 1) && (c <= gc + START_HI);
      chk("rnd_ack0", bus.o_ack0, g == 0);
      chk("rnd_ack1", bus.o_ack1, g == 1);
      chk("rnd_ready", bus.o_ready, free);
      chk("rnd_start", bus.o_start, exp_start);
      chk("rnd_rs", bus.o_rs, lrs);
      chk("rnd_data", bus.o_data, ldat);
      if (g == 0) begin
        next_free = c + WR_CYC; gc = c; ptr = 1;
        lrs = r0s; ldat = r0d; p0 = 0;
      end else if (g == 1) begin
        next_free = c + WR_CYC; gc = c; ptr = 0;
        lrs = r1s; ldat = r1d; p1 = 0;
      end
      @(negedge clk);
    end
    drop_reqs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who[$];
    int when[$];
    int c;

    tbl[0] = '{1, 0, 1, 0, 8'h41, 8'h00, 1, 0, 1, 8'h41};
    tbl[1] = '{0, 1, 0, 0, 8'h00, 8'h22, 0, 1, 0, 8'h22};
    tbl[2] = '{1, 1, 1, 0, 8'h30, 8'h31, 1, 0, 1, 8'h30};
    tbl[3] = '{1, 1, 1, 0, 8'h30, 8'h31, 0, 1, 0, 8'h31};
    tbl[4] = '{1, 1, 1, 0, 8'h30, 8'h31, 1, 0, 1, 8'h30};
    tbl[5] = '{1, 0, 0, 0, 8'h55, 8'h00, 1, 0, 0, 8'h55};
    tbl[6] = '{1, 1, 1, 1, 8'hAA, 8'h5A, 0, 1, 1, 8'h5A};
    tbl[7] = '{0, 1, 0, 0, 8'h00, 8'hA5, 0, 1, 0, 8'hA5};
    tbl[8] = '{1, 1, 0, 1, 8'h0F, 8'hF0, 1, 0, 0, 8'h0F};

    bus.i_req0 = 0; bus.i_req1 = 0;
    bus.i_rs0 = 0; bus.i_rs1 = 0;
    bus.i_data0 = 0; bus.i_data1 = 0;

    @(negedge clk);
    pulse_reset("rst");
    check_init("init");

    // Both requesters held from reset: grants alternate starting at 0.
    bus.i_req0 = 1; bus.i_rs0 = 0; bus.i_data0 = 8'h30;
    bus.i_req1 = 1; bus.i_rs1 = 0; bus.i_data1 = 8'h31;
    c = 0;
    while (who.size() < 4 && c < 4 * WR_CYC + 20) begin
      #1;
      if (bus.o_ack0) begin who.push_back(0); when.push_back(c); end
      if (bus.o_ack1) begin who.push_back(1); when.push_back(c); end
      @(negedge clk);
      c++;
    end
    drop_reqs();
    chk("rr_count", who.size(), 4);
    for (int i = 0; i < who.size(); i++) begin
      chk($sformatf("rr_who%0d", i), who[i], i % 2);
      if (i > 0) chk($sformatf("rr_gap%0d", i), when[i] - when[i-1], WR_CYC);
    end

    for (int i = 0; i < 9; i++) begin
      wait_ready();
      if (i > 0) begin
        chk($sformatf("tbl%0d_hold_rs", i), bus.o_rs, tbl[i-1].ers);
        chk($sformatf("tbl%0d_hold_data", i), bus.o_data, tbl[i-1].ed);
      end
      bus.i_req0 = tbl[i].r0; bus.i_rs0 = tbl[i].rs0; bus.i_data0 = tbl[i].d0;
      bus.i_req1 = tbl[i].r1; bus.i_rs1 = tbl[i].rs1; bus.i_data1 = tbl[i].d1;
      #1;
      chk($sformatf("tbl%0d_ack0", i), bus.o_ack0, tbl[i].a0);
      chk($sformatf("tbl%0d_ack1", i), bus.o_ack1, tbl[i].a1);
      @(negedge clk);
      drop_reqs();
      chk($sformatf("tbl%0d_rs", i), bus.o_rs, tbl[i].ers);
      chk($sformatf("tbl%0d_data", i), bus.o_data, tbl[i].ed);
      chk($sformatf("tbl%0d_start", i), bus.o_start, 1);
      chk($sformatf("tbl%0d_ready", i), bus.o_ready, 0);
    end

    // Single requester held: acks spaced by the full write latency.
    wait_ready();
    who.delete(); when.delete();
    bus.i_req0 = 1; bus.i_rs0 = 1; bus.i_data0 = 8'h41;
    c = 0;
    while (who.size() < 3 && c < 3 * WR_CYC + 20) begin
      #1;
      if (bus.o_ack0) begin who.push_back(0); when.push_back(c); end
      if (bus.o_ack1) begin who.push_back(1); when.push_back(c); end
      @(negedge clk);
      c++;
    end
    drop_reqs();
    chk("b2b_count", who.size(), 3);
    for (int i = 0; i < who.size(); i++) begin
      chk($sformatf("b2b_who%0d", i), who[i], 0);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), when[i] - when[i-1], WR_CYC);
    end

    // Done forced high through ISSUE and GUARD must not end the write.
    wait_ready();
    bus.i_req1 = 1; bus.i_rs1 = 0; bus.i_data1 = 8'h3C;
    #1;
    chk("stale_ack1", bus.o_ack1, 1);
    @(negedge clk);
    drop_reqs();
    force_done = 1'b1;
    chk("stale_start_t1", bus.o_start, 1);
    @(negedge clk);
    chk("stale_start_t2", bus.o_start, 1);
    @(negedge clk);
    chk("stale_start_t3", bus.o_start, 1);
    @(negedge clk);
    force_done = 1'b0;
    chk("stale_start_t4", bus.o_start, 1);
    repeat (START_HI - 4) @(negedge clk);
    chk("stale_start_last", bus.o_start, 1);
    @(negedge clk);
    chk("stale_start_fall", bus.o_start, 0);

    // Reset in the middle of WAIT_DONE aborts the write and reruns init.
    wait_ready();
    bus.i_req0 = 1; bus.i_rs0 = 1; bus.i_data0 = 8'h77;
    #1;
    chk("mid_ack0", bus.o_ack0, 1);
    @(negedge clk);
    drop_reqs();
    repeat (9) @(negedge clk);
    chk("mid_start_pre", bus.o_start, 1);
    pulse_reset("mid");
    check_init("reinit");

    run_random(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
